csr_timer_unit: RTL and testbench
=================================

// Module: csr_timer_unit
// PURPOSE
//  Timer and counter CSR block that sits beside csr_reg on the same CSR access bus.
//  Implements the TID, TCFG, TVAL and TICLR CSRs, the constant timer interrupt, and a 64-bit stable counter.
//  timer_int drives ESTAT.IS[11] in csr_reg.
//  cnt_value feeds the rdcntvl/rdcntvh datapath.
//  csr_hit tells the top-level read mux to take csr_rvalue from this block instead of csr_reg.
// PARAMETERS
//  TIMER_W     32  width of TCFG.InitVal+2 and of TVAL (fixed at 32 in this core)
//  COUNTER_ID  0   reset value of TID
// PORTS
//  clk         in   1   core clock; every register updates on posedge clk
//  reset       in   1   synchronous, active-high reset
//  csr_num     in   14  CSR address (TID=0x40, TCFG=0x41, TVAL=0x42, TICLR=0x44)
//  csr_we      in   1   write strobe, same cycle as csr_num/csr_wmask/csr_wvalue
//  csr_wmask   in   32  per-bit write mask
//  csr_wvalue  in   32  write data
//  csr_hit     out  1   csr_num is one of the four CSRs above (combinational)
//  csr_rvalue  out  32  read data for csr_num (combinational); 0 when csr_hit=0
//  timer_int   out  1   timer interrupt pending (registered)
//  cnt_value   out  64  stable counter (registered)
//  tid_value   out  32  TID contents, for rdcntid
// BEHAVIOUR
//  Masked write rule: new = (wmask & wvalue) | (~wmask & old).
//  Update priority, highest first: reset, CSR write, timer event.
//  Reset values:
//   - TID = COUNTER_ID
//   - TCFG = 0 (En=0)
//   - TVAL = 32'hFFFF_FFFF
//   - timer_int = 0
//   - cnt_value = 0
//  TCFG fields: [0] En, [1] Periodic, [31:2] InitVal.
//   - Fully writable; reads return the stored value.
//  TVAL is read-only; writes are ignored.
//   - Reads return the current count.
//  TICLR reads as 0.
//   - A write with wmask[0]&wvalue[0]=1 clears timer_int on the next edge.
//   - Other TICLR bits have no effect.
//  Counting, evaluated each cycle (uses the old En/Periodic/InitVal values):
//   - TCFG written with new En=1: TVAL <= {new InitVal,2'b00} next edge; no decrement that cycle.
//   - TCFG written with new En=0: TVAL holds its value; the timer stops.
//   - No TCFG write, En=1, TVAL!=0: TVAL <= TVAL-1.
//   - No TCFG write, En=1, TVAL==0 (timer event): timer_int <= 1.
//     - Periodic=1: TVAL <= {InitVal,2'b00}.
//     - Periodic=0: TVAL <= 32'hFFFF_FFFF and En <= 0 (one-shot ends).
//   - En=0: TVAL holds.
//  Timer event and TICLR clear in the same cycle: set wins, timer_int stays 1.
//  timer_int stays 1 until a TICLR clear or reset.
//   - A second timer event while timer_int=1 changes nothing.
//  InitVal=0 with Periodic=1: the event fires every cycle after load; this is legal.
//  Stable counter: +1 every cycle after reset; wraps 64'hFFFF..FF -> 0.
//   - Not writable via CSR.
//  Reset asserted mid-count: all state returns to reset values on that edge.
//   - A simultaneous CSR write is discarded.
//  Latency: any write is visible on csr_rvalue the cycle after the write edge.
//   - Reads of the current cycle return the pre-write value.
// TESTING
//  T1 Reset: hold reset 2 cycles
//   -> TCFG=0, TVAL=FFFF_FFFF, timer_int=0, cnt_value=0, TID=COUNTER_ID.
//  T2 One-shot: write TCFG=0x0000_0009, mask FFFF_FFFF
//   -> TVAL=8 next cycle, then 7..0.
//   -> timer_int=1 the cycle after TVAL=0; TVAL=FFFF_FFFF; TCFG reads 0x0000_0008.
//  T3 Periodic: write TCFG=0x0000_000B
//   -> TVAL sequence 8,7..0,8,7..; timer event every 9 cycles.
//   -> clear via TICLR=1 between events; timer_int re-asserts at the next event.
//  T4 Clear vs set: TICLR write lands in the same cycle as TVAL=0 with En=1 -> timer_int stays 1.
//   -> TICLR write one cycle later -> timer_int=0.
//  T5 Masked/ignored writes:
//   -> TCFG write wvalue=FFFF_FFFF, wmask=0000_0002 sets Periodic only; En stays 0, TVAL unchanged.
//   -> TVAL write changes nothing; TICLR reads 0.
//  T6 Counter and read mux: cnt_value increases by exactly 1 per cycle across 1000 cycles, including reset release.
//   -> csr_hit=0 and csr_rvalue=0 for csr_num=0x00.

Source files
------------

// File: rtl/csr_timer_unit.sv
// rtl/csr_timer_unit.sv - TID/TCFG/TVAL/TICLR timer CSRs, timer interrupt and 64-bit stable counter
module csr_timer_unit #(
  parameter int          TIMER_W    = 32,
  parameter logic [31:0] COUNTER_ID = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic        csr_hit,
  output logic [31:0] csr_rvalue,
  output logic        timer_int,
  output logic [63:0] cnt_value,
  output logic [31:0] tid_value
);

  localparam logic [13:0] ADDR_TID   = 14'h40;
  localparam logic [13:0] ADDR_TCFG  = 14'h41;
  localparam logic [13:0] ADDR_TVAL  = 14'h42;
  localparam logic [13:0] ADDR_TICLR = 14'h44;

  logic [31:0]        tid;
  logic [31:0]        tcfg;
  logic [TIMER_W-1:0] tval;

  logic        tid_we;
  logic        tcfg_we;
  logic        ticlr_clr;
  logic        timer_event;
  logic [31:0] tid_new;
  logic [31:0] tcfg_new;

  assign tid_we    = csr_we && (csr_num == ADDR_TID);
  assign tcfg_we   = csr_we && (csr_num == ADDR_TCFG);
  assign ticlr_clr = csr_we && (csr_num == ADDR_TICLR) && csr_wmask[0] && csr_wvalue[0];

  assign tid_new  = (csr_wmask & csr_wvalue) | (~csr_wmask & tid);
  assign tcfg_new = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg);

  // A TCFG write in the same cycle pre-empts counting, so it also suppresses the event.
  assign timer_event = !tcfg_we && tcfg[0] && (tval == '0);

  assign tid_value = tid;

  always_ff @(posedge clk) begin
    if (reset) begin
      tid       <= COUNTER_ID;
      tcfg      <= 32'h0;
      tval      <= '1;
      timer_int <= 1'b0;
      cnt_value <= 64'h0;
    end else begin
      cnt_value <= cnt_value + 64'h1;

      if (tid_we) begin
        tid <= tid_new;
      end

      if (tcfg_we) begin
        tcfg <= tcfg_new;
        if (tcfg_new[0]) begin
          tval <= TIMER_W'({tcfg_new[31:2], 2'b00});
        end
      end else if (tcfg[0]) begin
        if (tval != '0) begin
          tval <= tval - TIMER_W'(1);
        end else if (tcfg[1]) begin
          tval <= TIMER_W'({tcfg[31:2], 2'b00});
        end else begin
          tval    <= '1;
          tcfg[0] <= 1'b0;
        end
      end

      // Set beats clear when both land on the same edge.
      if (timer_event) begin
        timer_int <= 1'b1;
      end else if (ticlr_clr) begin
        timer_int <= 1'b0;
      end
    end
  end

  always_comb begin
    csr_hit    = 1'b0;
    csr_rvalue = 32'h0;
    case (csr_num)
      ADDR_TID: begin
        csr_hit    = 1'b1;
        csr_rvalue = tid;
      end
      ADDR_TCFG: begin
        csr_hit    = 1'b1;
        csr_rvalue = tcfg;
      end
      ADDR_TVAL: begin
        csr_hit    = 1'b1;
        csr_rvalue = 32'(tval);
      end
      ADDR_TICLR: begin
        csr_hit = 1'b1;
      end
      default: begin
        csr_hit    = 1'b0;
        csr_rvalue = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_timer_unit.sv
// tb/tb_csr_timer_unit.sv - self-checking bench for csr_timer_unit
module tb_csr_timer_unit;

  localparam logic [31:0] CID = 32'h0000_005A;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        csr_hit;
  logic [31:0] csr_rvalue;
  logic        timer_int;
  logic [63:0] cnt_value;
  logic [31:0] tid_value;

  always #5 clk = ~clk;

  csr_timer_unit #(.TIMER_W(32), .COUNTER_ID(CID)) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_num    (csr_num),
    .csr_we     (csr_we),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .csr_hit    (csr_hit),
    .csr_rvalue (csr_rvalue),
    .timer_int  (timer_int),
    .cnt_value  (cnt_value),
    .tid_value  (tid_value)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state, kept as architectural fields rather than raw registers.
  logic [31:0] m_tid;
  bit          m_en, m_per;
  logic [29:0] m_init;
  logic [31:0] m_tval;
  bit          m_int;
  logic [63:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_tcfg();
    return {m_init, m_per, m_en};
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] n);
    case (n)
      14'h40:  return m_tid;
      14'h41:  return m_tcfg();
      14'h42:  return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_hit(input logic [13:0] n);
    return (n == 14'h40) || (n == 14'h41) || (n == 14'h42) || (n == 14'h44);
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [13:0] n,
                            input logic [31:0] m, input logic [31:0] v);
    logic [31:0] old_cfg, new_cfg;
    bit fired;
    if (rst) begin
      m_tid = CID; m_en = 0; m_per = 0; m_init = '0;
      m_tval = 32'hFFFF_FFFF; m_int = 0; m_cnt = 64'h0;
      return;
    end
    m_cnt   = m_cnt + 64'd1;
    fired   = 0;
    old_cfg = m_tcfg();
    if (we && n == 14'h40) m_tid = (m & v) | (~m & m_tid);
    if (we && n == 14'h41) begin
      new_cfg = (m & v) | (~m & old_cfg);
      {m_init, m_per, m_en} = new_cfg;
      if (m_en) m_tval = 32'(m_init) * 4;
    end else if (old_cfg[0]) begin
      if (m_tval > 0) m_tval = m_tval - 1;
      else begin
        fired = 1;
        m_int = 1;
        if (old_cfg[1]) m_tval = 32'(old_cfg[31:2]) * 4;
        else begin
          m_tval = 32'hFFFF_FFFF;
          m_en   = 0;
        end
      end
    end
    if (we && n == 14'h44 && (m[0] & v[0]) && !fired) m_int = 0;
  endtask

  // One clock: drive, check combinational read, clock, check registered outputs.
  task automatic step(input bit rst, input bit we, input logic [13:0] n,
                      input logic [31:0] m, input logic [31:0] v,
                      output logic [31:0] rd, output logic hit);
    reset = rst; csr_we = we; csr_num = n; csr_wmask = m; csr_wvalue = v;
    #1;
    rd  = csr_rvalue;
    hit = csr_hit;
    if (!rst) begin
      chk("csr_hit", {63'h0, csr_hit}, {63'h0, model_hit(n)});
      chk("csr_rvalue", {32'h0, csr_rvalue}, {32'h0, model_read(n)});
    end
    @(posedge clk);
    model_edge(rst, we, n, m, v);
    #1;
    chk("timer_int", {63'h0, timer_int}, {63'h0, m_int});
    chk("cnt_value", cnt_value, m_cnt);
    chk("tid_value", {32'h0, tid_value}, {32'h0, m_tid});
  endtask

  typedef struct {
    bit          we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wval;
    bit          exp_hit;
    logic [31:0] exp_rd;
    bit          exp_int;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit we, input logic [13:0] n, input logic [31:0] m,
                              input logic [31:0] v, input bit h, input logic [31:0] r, input bit i);
    vec_t e;
    e.we = we; e.num = n; e.mask = m; e.wval = v; e.exp_hit = h; e.exp_rd = r; e.exp_int = i;
    tbl.push_back(e);
  endfunction

  logic [31:0] rd;
  logic        hit;
  logic [63:0] prev_cnt;

  initial begin
    reset = 1; csr_we = 0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;

    // T1 reset, T5 masked/ignored writes, T2 one-shot
    add(0, 14'h41, 0, 0, 1, 32'h0, 0);
    add(0, 14'h42, 0, 0, 1, 32'hFFFF_FFFF, 0);
    add(0, 14'h40, 0, 0, 1, CID, 0);
    add(0, 14'h44, 0, 0, 1, 32'h0, 0);
    add(1, 14'h41, 32'h0000_0002, 32'hFFFF_FFFF, 1, 32'h0, 0);
    add(0, 14'h41, 0, 0, 1, 32'h0000_0002, 0);
    add(0, 14'h42, 0, 0, 1, 32'hFFFF_FFFF, 0);
    add(1, 14'h42, 32'hFFFF_FFFF, 32'h0, 1, 32'hFFFF_FFFF, 0);
    add(0, 14'h42, 0, 0, 1, 32'hFFFF_FFFF, 0);
    add(1, 14'h44, 32'h1, 32'h1, 1, 32'h0, 0);
    add(0, 14'h00, 0, 0, 0, 32'h0, 0);
    add(1, 14'h41, 32'hFFFF_FFFF, 32'h0000_0009, 1, 32'h0000_0002, 0);
    for (int k = 8; k >= 0; k--) add(0, 14'h42, 0, 0, 1, 32'(k), (k == 0));
    add(0, 14'h42, 0, 0, 1, 32'hFFFF_FFFF, 1);
    add(0, 14'h41, 0, 0, 1, 32'h0000_0008, 1);
    add(1, 14'h44, 32'h1, 32'h1, 1, 32'h0, 0);

    @(posedge clk); #1;
    step(1, 0, 14'h0, 0, 0, rd, hit);
    step(1, 0, 14'h0, 0, 0, rd, hit);
    chk("reset_cnt", cnt_value, 64'h0);
    chk("reset_tid", {32'h0, tid_value}, {32'h0, CID});

    foreach (tbl[i]) begin
      step(0, tbl[i].we, tbl[i].num, tbl[i].mask, tbl[i].wval, rd, hit);
      chk($sformatf("tbl%0d_hit", i), {63'h0, hit}, {63'h0, tbl[i].exp_hit});
      chk($sformatf("tbl%0d_rd", i), {32'h0, rd}, {32'h0, tbl[i].exp_rd});
      chk($sformatf("tbl%0d_int", i), {63'h0, timer_int}, {63'h0, tbl[i].exp_int});
    end

    // T3/T4 periodic: 9-cycle period, clear between events, clear colliding with an event
    step(0, 1, 14'h41, 32'hFFFF_FFFF, 32'h0000_000B, rd, hit);
    for (int k = 0; k <= 12; k++) begin
      step(0, 0, 14'h42, 0, 0, rd, hit);
      chk("per_tval", {32'h0, rd}, {32'h0, 32'(8 - (k % 9))});
      chk("per_int", {63'h0, timer_int}, {63'h0, (k >= 8)});
    end
    step(0, 1, 14'h44, 32'h1, 32'h1, rd, hit);
    chk("per_clear", {63'h0, timer_int}, 64'h0);
    for (int k = 14; k <= 16; k++) begin
      step(0, 0, 14'h42, 0, 0, rd, hit);
      chk("per_tval2", {32'h0, rd}, {32'h0, 32'(17 - k)});
    end
    step(0, 1, 14'h44, 32'h1, 32'h1, rd, hit);
    chk("set_wins", {63'h0, timer_int}, 64'h1);
    step(0, 1, 14'h44, 32'h1, 32'h1, rd, hit);
    chk("late_clear", {63'h0, timer_int}, 64'h0);
    step(0, 0, 14'h42, 0, 0, rd, hit);
    chk("reload_tval", {32'h0, rd}, 64'h7);

    // T6 random traffic with reset mid-count; counter must step by one
    step(1, 1, 14'h41, 32'hFFFF_FFFF, 32'h0000_0007, rd, hit);
    step(0, 0, 14'h41, 0, 0, rd, hit);
    chk("reset_discard", {32'h0, rd}, 64'h0);
    prev_cnt = cnt_value;
    for (int i = 0; i < 1000; i++) begin
      logic [13:0] n;
      logic [31:0] m, v;
      bit r, w;
      case ($urandom_range(0, 5))
        0: n = 14'h40;
        1: n = 14'h41;
        2: n = 14'h42;
        3: n = 14'h44;
        4: n = 14'h00;
        default: n = 14'($urandom);
      endcase
      w = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      v = (n == 14'h41) ? ($urandom & 32'h0000_001F) : $urandom;
      r = ($urandom_range(0, 199) == 0);
      step(r, w, n, m, v, rd, hit);
      chk("cnt_step", cnt_value, r ? 64'h0 : prev_cnt + 64'd1);
      prev_cnt = cnt_value;
    end
    step(0, 0, 14'h00, 0, 0, rd, hit);
    chk("unmapped_hit", {63'h0, hit}, 64'h0);
    chk("unmapped_rd", {32'h0, rd}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
